// File: rtl/wb_pkg.sv
// Shared widths and the write-port entry type for the writeback unit.
package wb_pkg;
   localparam int DATA_W   = 48;
   localparam int ADR_W    = 2;
   localparam int NUM_REGS = 1 << ADR_W;

   typedef struct packed {
      logic [ADR_W-1:0]  adr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-port entries; the head entry is visible combinationally.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  wb_entry_t din,
   output wb_entry_t dout,
   output logic      full,
   output logic      empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   wb_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            push_ok, pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter: ALU first, buffered loads otherwise, plus load scoreboard.
// Optional WB_FORWARD_EN adds write-cycle bypass hit outputs.
module writeback_unit #(
   parameter int DATA_W       = 48,
   parameter int ADR_W        = 2,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [ADR_W-1:0]      alu_adr,
   input  logic [DATA_W-1:0]     alu_data,
   output logic                  alu_stall,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADR_W-1:0]      mem_adr,
   input  logic [DATA_W-1:0]     mem_data,
   input  logic                  issue_en,
   input  logic                  issue_mem,
   input  logic [ADR_W-1:0]      issue_adr,
   output logic [0:2**ADR_W-1]   pending,
`ifdef WB_FORWARD_EN
   input  logic [ADR_W-1:0]      fwd_adr_a,
   input  logic [ADR_W-1:0]      fwd_adr_b,
   output logic                  fwd_hit_a,
   output logic                  fwd_hit_b,
`endif
   output logic                  write_en,
   output logic [ADR_W-1:0]      write_adr,
   output logic [0:DATA_W-1]     write_data
);
   import wb_pkg::*;

   localparam int NUM_REGS = 2**ADR_W;
   localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);

   wb_entry_t            head, push_ent, sel;
   logic                 fifo_full, fifo_empty, push, pop;
   logic [CNT_W-1:0]     starve_cnt, starve_nxt;
   logic [0:NUM_REGS-1]  pend_nxt;

   assign mem_ready = !fifo_full;
   assign push      = mem_valid && !fifo_full;
   assign pop       = !alu_valid && !fifo_empty;
   assign push_ent  = '{adr: mem_adr, data: mem_data};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_ent),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      sel = head;
      if (alu_valid) sel = '{adr: alu_adr, data: alu_data};
   end

   // Counts cycles the buffered head was passed over; any pop or an empty FIFO restarts it.
   assign starve_nxt = (pop || fifo_empty) ? '0 : starve_cnt + 1'b1;

   // Clear before set so an issue to the register being popped stays pending.
   always_comb begin
      pend_nxt = pending;
      if (pop) pend_nxt[head.adr] = 1'b0;
      if (issue_en && issue_mem) pend_nxt[issue_adr] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         alu_stall  <= 1'b0;
         pending    <= '0;
         write_en   <= 1'b0;
         write_adr  <= '0;
         write_data <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         alu_stall  <= (starve_nxt == CNT_W'(STARVE_LIMIT));
         pending    <= pend_nxt;
         write_en   <= alu_valid || !fifo_empty;
         if (alu_valid || !fifo_empty) begin
            write_adr  <= sel.adr;
            write_data <= sel.data;
         end
      end
   end

`ifdef WB_FORWARD_EN
   assign fwd_hit_a = write_en && (write_adr == fwd_adr_a);
   assign fwd_hit_b = write_en && (write_adr == fwd_adr_b);
`endif
endmodule
